scarv_cop_malu_mul: RTL and testbench
=====================================

# scarv_cop_malu_mul

Sequential multi-precision multiply-accumulate unit sitting directly upstream of the coprocessor's combinational multi-precision ALU writeback path. It computes the 64-bit unsigned result of rs1*rs2 + rs3 over several cycles. It presents the high and low 32-bit halves, with a one-cycle done pulse, to the register writeback logic that the combinational ALU also feeds. It isolates the long-latency multiply so the combinational ALU stays single-cycle.

## Interface
Parameters:
- MUL_UNROLL, default 1: multiplier bits consumed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- g_clk  in  1  coprocessor clock; all state is updated on the rising edge.
- g_resetn  in  1  asynchronous, active-low reset.
- mul_ivalid  in  1  start request; operands are sampled when it is accepted.
- mul_ready  out  1  unit is idle and will accept mul_ivalid this cycle.
- mul_flush  in  1  abort the in-flight operation (pipeline flush or trap).
- mul_rs1  in  32  multiplicand, unsigned.
- mul_rs2  in  32  multiplier, unsigned.
- mul_rs3  in  32  addend, unsigned.
- mul_idone  out  1  single-cycle pulse; the result is valid this cycle.
- mul_rd_hi  out  32  result bits [63:32].
- mul_rd_lo  out  32  result bits [31:0].

## Operation
- State machine: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - mul_ready=1.
  - On mul_ivalid=1 and mul_flush=0: latch rs1 into the multiplicand register; load hi=rs3 and lo=rs2; clear the step counter; go to RUN.
- RUN, one step per cycle:
  - Compute hi_ext = hi + rs1_q*lo[MUL_UNROLL-1:0]. hi_ext is (32+MUL_UNROLL) bits wide and is computed without truncation.
  - Shift {hi_ext, lo} right by MUL_UNROLL bits into {hi, lo}.
  - Increment the counter.
  - After step 32/MUL_UNROLL - 1, go to DONE.
  - Loading rs3 into hi yields rs1*rs2 + rs3 exactly. The maximum value (2^32-1)^2 + (2^32-1) fits in 64 bits, so there is no overflow.
- DONE:
  - mul_idone=1 for exactly one cycle; {mul_rd_hi, mul_rd_lo} = {hi, lo}.
  - Next state is IDLE.
- mul_rd_hi and mul_rd_lo are driven directly from the hi and lo registers. They hold the last result in IDLE until the next accept.
  - Outside DONE the values are don't-care to consumers. The bench checks them only on mul_idone.
- mul_ready is 1 only in IDLE, so no new start is possible in RUN or DONE. mul_ivalid is ignored there.
- mul_flush:
  - In RUN: return to IDLE next cycle with no mul_idone pulse.
  - In DONE: mul_idone is suppressed that cycle (mul_idone = DONE & ~mul_flush).
  - In IDLE with mul_ivalid=1: the flush wins and the request is not accepted.
- Counter width is 5 bits and never wraps in normal use. Its terminal value depends on MUL_UNROLL (31, 15 or 7).

## Timing
- Reset values: state IDLE; mul_ready=1; mul_idone=0; hi, lo, rs1_q and counter all 0, so mul_rd_hi=0 and mul_rd_lo=0.
- Accept happens at edge T0, when mul_ivalid & mul_ready & ~mul_flush is sampled high.
- RUN occupies 32/MUL_UNROLL cycles after T0.
- mul_idone is high during cycle T0 + 32/MUL_UNROLL + 1:
  - 33 cycles for MUL_UNROLL=1.
  - 17 cycles for MUL_UNROLL=2.
  - 9 cycles for MUL_UNROLL=4.
- mul_ready returns high the cycle after mul_idone. Maximum throughput is one operation per 32/MUL_UNROLL + 2 cycles.
- Asserting g_resetn low mid-operation returns all state to reset values immediately, asynchronously. No mul_idone pulse is produced for the aborted operation.
- Operand inputs may change freely after the accept edge.
- No combinational path from mul_rs* to any output.
- mul_ready depends only on state. mul_idone depends on state and mul_flush.

## Test plan
- MUL_UNROLL=1: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF, rs3=0xFFFFFFFF -> mul_idone exactly 33 cycles after accept; hi=0xFFFFFFFF, lo=0x00000000.
- rs1=0x12345678, rs2=0x9ABCDEF0, rs3=0x00000001 -> {hi,lo}=0x0B00EA4E_242D2081, checked for MUL_UNROLL 1, 2 and 4, with latencies 33, 17 and 9 respectively.
- rs2=0 and rs3=0xDEADBEEF -> hi=0, lo=0xDEADBEEF. rs1=0, rs2=5, rs3=0 -> all zero.
- Hold mul_ivalid high continuously with changing operands -> each accept occurs only when mul_ready=1. Each result matches the operands sampled at its own accept. There is exactly one mul_idone per accept.
- Flush cases, each of which must end in IDLE with mul_ready=1 on the next cycle:
  - Assert mul_flush at RUN step 10 -> no mul_idone.
  - Assert mul_flush in DONE -> mul_idone stays 0.
  - Assert mul_flush together with mul_ivalid in IDLE -> no accept.
- Pulse g_resetn low at RUN step 20 -> outputs return to reset values immediately. A subsequent operation (3*4+5) yields lo=0x11 and hi=0.

Source files
------------

// File: rtl/scarv_cop_malu_mul_if.sv
// Handshake and operand/result bundle between the coprocessor issue logic
// and the sequential multiply-accumulate unit.
interface scarv_cop_malu_mul_if;
    logic        mul_ivalid;
    logic        mul_ready;
    logic        mul_flush;
    logic [31:0] mul_rs1;
    logic [31:0] mul_rs2;
    logic [31:0] mul_rs3;
    logic        mul_idone;
    logic [31:0] mul_rd_hi;
    logic [31:0] mul_rd_lo;

    modport master (
        output mul_ivalid, mul_flush, mul_rs1, mul_rs2, mul_rs3,
        input  mul_ready, mul_idone, mul_rd_hi, mul_rd_lo
    );

    modport slave (
        input  mul_ivalid, mul_flush, mul_rs1, mul_rs2, mul_rs3,
        output mul_ready, mul_idone, mul_rd_hi, mul_rd_lo
    );
endinterface

// File: rtl/scarv_cop_malu_mul.sv
// Sequential shift-add multiply-accumulate: {rd_hi, rd_lo} = rs1*rs2 + rs3,
// consuming MUL_UNROLL multiplier bits per cycle.
module scarv_cop_malu_mul #(
    parameter int MUL_UNROLL = 1
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    scarv_cop_malu_mul_if.slave  mul
);

    generate
        if (!(MUL_UNROLL == 1 || MUL_UNROLL == 2 || MUL_UNROLL == 4)) begin : g_bad_unroll
            $error("scarv_cop_malu_mul: MUL_UNROLL must be 1, 2 or 4");
        end
    endgenerate

    localparam int         W        = 32 + MUL_UNROLL;
    localparam logic [4:0] CNT_LAST = 5'(32 / MUL_UNROLL - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rs1_q, rs1_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        accept;
    logic [W-1:0] hi_ext;

    assign accept = (state_q == S_IDLE) && mul.mul_ivalid && !mul.mul_flush;

    // hi starts as rs3, so the addend rides along in the partial-product sum;
    // W bits are enough because hi + rs1*(2^U-1) < 2^(32+U).
    assign hi_ext = W'(hi_q) + W'(rs1_q) * W'(lo_q[MUL_UNROLL-1:0]);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN: begin
                if (mul.mul_flush)          state_d = S_IDLE;
                else if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mul.mul_ready = (state_q == S_IDLE);
        mul.mul_idone = (state_q == S_DONE) && !mul.mul_flush;
        mul.mul_rd_hi = hi_q;
        mul.mul_rd_lo = lo_q;
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        rs1_d = rs1_q;
        cnt_d = cnt_q;
        if (accept) begin
            rs1_d = mul.mul_rs1;
            hi_d  = mul.mul_rs3;
            lo_d  = mul.mul_rs2;
            cnt_d = 5'd0;
        end else if (state_q == S_RUN) begin
            hi_d  = hi_ext[W-1:MUL_UNROLL];
            lo_d  = {hi_ext[MUL_UNROLL-1:0], lo_q[31:MUL_UNROLL]};
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            hi_q  <= '0;
            lo_q  <= '0;
            rs1_q <= '0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            rs1_q <= rs1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_scarv_cop_malu_mul.sv
// Bench for scarv_cop_malu_mul: three instances (unroll 1, 2, 4) checked
// against a plain 64-bit arithmetic model of rs1*rs2 + rs3.
module tb_scarv_cop_malu_mul;

    logic        g_clk;
    logic        g_resetn;
    logic [2:0]  ivalid;
    logic [2:0]  flush;
    logic [31:0] rs1, rs2, rs3;
    logic [2:0]  ready;
    logic [2:0]  idone;
    logic [31:0] rd_hi [3];
    logic [31:0] rd_lo [3];

    int total;
    int bad;

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int U = 1 << g;
        scarv_cop_malu_mul_if ifc ();
        assign ifc.mul_ivalid = ivalid[g];
        assign ifc.mul_flush  = flush[g];
        assign ifc.mul_rs1    = rs1;
        assign ifc.mul_rs2    = rs2;
        assign ifc.mul_rs3    = rs3;
        assign ready[g]       = ifc.mul_ready;
        assign idone[g]       = ifc.mul_idone;
        assign rd_hi[g]       = ifc.mul_rd_hi;
        assign rd_lo[g]       = ifc.mul_rd_lo;
        scarv_cop_malu_mul #(.MUL_UNROLL(U)) dut (
            .g_clk    (g_clk),
            .g_resetn (g_resetn),
            .mul      (ifc)
        );
    end

    function automatic logic [63:0] model(input logic [31:0] a, b, c);
        logic [63:0] r;
        r = {32'd0, a} * {32'd0, b} + {32'd0, c};
        return r;
    endfunction

    function automatic int exp_lat(input int u);
        return 32 / (1 << u) + 1;
    endfunction

    // Launch one op at the current negedge; return latency (cycles from the
    // accept edge to the done cycle) and the result seen on done.
    task automatic run_op(input int u, input logic [31:0] a, b, c,
                          output int lat, output logic [63:0] res);
        lat = -1;
        res = '0;
        rs1 = a; rs2 = b; rs3 = c;
        ivalid[u] = 1'b1;
        @(negedge g_clk);
        ivalid[u] = 1'b0;
        rs1 = $urandom; rs2 = $urandom; rs3 = $urandom;
        for (int k = 1; k <= 80; k++) begin
            if (idone[u]) begin
                lat = k;
                res = {rd_hi[u], rd_lo[u]};
                break;
            end
            @(negedge g_clk);
        end
        @(negedge g_clk);
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        repeat (3) @(negedge g_clk);
        for (int u = 0; u < 3; u++) begin
            total++;
            if (ready[u] !== 1'b1 || idone[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_ctl u=%0d ready=%b idone=%b want 1/0", u, ready[u], idone[u]);
            end
            total++;
            if ({rd_hi[u], rd_lo[u]} !== 64'd0) begin
                bad++;
                $display("FAIL reset_data u=%0d got=%h want 0", u, {rd_hi[u], rd_lo[u]});
            end
        end
        g_resetn = 1'b1;
        @(negedge g_clk);
    endtask

    task automatic test_directed();
        int          tu  [6] = '{0, 0, 1, 2, 0, 1};
        logic [31:0] ta  [6] = '{32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'h12345678, 32'h11111111, 32'h0};
        logic [31:0] tb  [6] = '{32'hFFFFFFFF, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h0, 32'd5};
        logic [31:0] tc  [6] = '{32'hFFFFFFFF, 32'h1, 32'h1, 32'h1, 32'hDEADBEEF, 32'h0};
        logic [63:0] te  [6] = '{64'hFFFFFFFF_00000000, 64'h0B00EA4E_242D2081, 64'h0B00EA4E_242D2081,
                                 64'h0B00EA4E_242D2081, 64'h00000000_DEADBEEF, 64'h0};
        int          lat;
        logic [63:0] res;
        for (int i = 0; i < 6; i++) begin
            run_op(tu[i], ta[i], tb[i], tc[i], lat, res);
            total++;
            if (lat != exp_lat(tu[i])) begin
                bad++;
                $display("FAIL directed_lat #%0d got=%0d want=%0d", i, lat, exp_lat(tu[i]));
            end
            total++;
            if (res !== te[i]) begin
                bad++;
                $display("FAIL directed_res #%0d got=%h want=%h", i, res, te[i]);
            end
            total++;
            if (ready[tu[i]] !== 1'b1) begin
                bad++;
                $display("FAIL directed_ready #%0d got=%b want 1", i, ready[tu[i]]);
            end
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [63:0] res;
        logic [31:0] a, b, c;
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 6; i++) begin
                a = $urandom; b = $urandom; c = $urandom;
                if (i == 0) a = 32'hFFFFFFFF;
                if (i == 1) b = 32'h80000001;
                run_op(u, a, b, c, lat, res);
                total++;
                if (lat != exp_lat(u) || res !== model(a, b, c)) begin
                    bad++;
                    $display("FAIL random u=%0d a=%h b=%h c=%h got=%h lat=%0d want=%h lat=%0d",
                             u, a, b, c, res, lat, model(a, b, c), exp_lat(u));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        int          n_acc  = 0;
        int          n_done = 0;
        logic        acc_pend = 1'b0;
        int          u = 1;
        ivalid[u] = 1'b1;
        for (int k = 0; k < 140; k++) begin
            if (acc_pend) begin
                total++;
                if (ready[u] !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_accept cyc=%0d ready=%b want 0", k, ready[u]);
                end
            end
            if (idone[u]) begin
                n_done++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_spurious cyc=%0d got=%h want none", k, {rd_hi[u], rd_lo[u]});
                end else if ({rd_hi[u], rd_lo[u]} !== exp_q[0]) begin
                    bad++;
                    $display("FAIL b2b_res cyc=%0d got=%h want=%h", k, {rd_hi[u], rd_lo[u]}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (k == 100) ivalid[u] = 1'b0;
            rs1 = $urandom; rs2 = $urandom; rs3 = $urandom;
            acc_pend = ivalid[u] && ready[u];
            if (acc_pend) begin
                exp_q.push_back(model(rs1, rs2, rs3));
                n_acc++;
            end
            @(negedge g_clk);
        end
        total++;
        if (n_acc < 4 || n_done != n_acc || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count acc=%0d done=%0d left=%0d want done=acc>=4 left=0",
                     n_acc, n_done, exp_q.size());
        end
    endtask

    task automatic count_done(input int u, input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            if (idone[u]) n++;
            @(negedge g_clk);
        end
    endtask

    task automatic test_flush_run();
        int n;
        rs1 = 32'h1234; rs2 = 32'h5678; rs3 = 32'h9;
        ivalid[0] = 1'b1;
        @(negedge g_clk);
        ivalid[0] = 1'b0;
        repeat (10) @(negedge g_clk);
        flush[0] = 1'b1;
        @(negedge g_clk);
        flush[0] = 1'b0;
        total++;
        if (ready[0] !== 1'b1 || idone[0] !== 1'b0) begin
            bad++;
            $display("FAIL flush_run_idle ready=%b idone=%b want 1/0", ready[0], idone[0]);
        end
        count_done(0, 40, n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL flush_run_done got=%0d pulses want 0", n);
        end
    endtask

    task automatic test_flush_done();
        int n;
        rs1 = 32'h7; rs2 = 32'h8; rs3 = 32'h9;
        ivalid[2] = 1'b1;
        @(negedge g_clk);
        ivalid[2] = 1'b0;
        repeat (8) @(negedge g_clk);
        total++;
        if (idone[2] !== 1'b1) begin
            bad++;
            $display("FAIL flush_done_pre idone=%b want 1", idone[2]);
        end
        flush[2] = 1'b1;
        #1;
        total++;
        if (idone[2] !== 1'b0) begin
            bad++;
            $display("FAIL flush_done_suppress idone=%b want 0", idone[2]);
        end
        @(negedge g_clk);
        flush[2] = 1'b0;
        total++;
        if (ready[2] !== 1'b1) begin
            bad++;
            $display("FAIL flush_done_idle ready=%b want 1", ready[2]);
        end
        count_done(2, 20, n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL flush_done_after got=%0d pulses want 0", n);
        end
    endtask

    task automatic test_flush_idle();
        int n;
        ivalid[0] = 1'b1;
        flush[0]  = 1'b1;
        @(negedge g_clk);
        ivalid[0] = 1'b0;
        flush[0]  = 1'b0;
        total++;
        if (ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL flush_idle_accept ready=%b want 1", ready[0]);
        end
        count_done(0, 40, n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL flush_idle_done got=%0d pulses want 0", n);
        end
    endtask

    task automatic test_reset_mid();
        int          n, lat;
        logic [63:0] res;
        rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; rs3 = 32'hFFFFFFFF;
        ivalid[0] = 1'b1;
        @(negedge g_clk);
        ivalid[0] = 1'b0;
        repeat (20) @(negedge g_clk);
        g_resetn = 1'b0;
        #1;
        total++;
        if (ready[0] !== 1'b1 || idone[0] !== 1'b0 || {rd_hi[0], rd_lo[0]} !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid ready=%b idone=%b res=%h want 1/0/0",
                     ready[0], idone[0], {rd_hi[0], rd_lo[0]});
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        count_done(0, 40, n);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL reset_mid_done got=%0d pulses want 0", n);
        end
        run_op(0, 32'd3, 32'd4, 32'd5, lat, res);
        total++;
        if (res !== 64'h11 || lat != 33) begin
            bad++;
            $display("FAIL reset_mid_after got=%h lat=%0d want=%h lat=33", res, lat, 64'h11);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        ivalid = '0;
        flush  = '0;
        rs1 = '0; rs2 = '0; rs3 = '0;
        g_resetn = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush_run();
        test_flush_done();
        test_flush_idle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
